inout_face_manager_n: RTL
=========================

Name: inout_face_manager_n

Overview:
- Parametrised successor to the three-channel TS4231 pad manager.
- Owns N bidirectional data/envelope pad pairs (ECP5 TRELLIS_IO BIDIR, LVCMOS33) and presents synchronised data samples from both clock edges.
- Envelope path adds a glitch filter, bus-turnaround guard, edge pulses and a free-running-counter timestamp on each envelope rising edge.
- Sits between the sensor pads and the per-sensor decoders/configurators.

Parameters:
N_CH, 3, number of sensor channels
SYNC_STAGES, 2, posedge synchroniser flops after first capture (min 1)
ENV_FILT_LEN, 4, consecutive agreeing cycles before filtered envelope changes (min 1)
GUARD_CYCLES, 8, input blanking cycles after an output enable deasserts
TS_W, 16, timestamp counter width

Ports:
clk_96MHz  in  1  system clock
rst_n  in  1  synchronous reset, active-low
data_wire  inout  N_CH  data pads
d_oe  in  N_CH  data drive enable (1 = drive)
d_out  in  N_CH  data drive value
d_in_0  out  N_CH  synchronised posedge data sample
d_in_1  out  N_CH  synchronised negedge data sample (half-cycle before d_in_0's sample)
d_rx_en  out  N_CH  1 = data inputs valid (not driving, not in guard)
envelop_wire  inout  N_CH  envelope pads
e_oe  in  N_CH  envelope drive enable
e_out  in  N_CH  envelope drive value
e_in  out  N_CH  filtered envelope level
e_rise  out  N_CH  1-cycle pulse on e_in 0->1
e_fall  out  N_CH  1-cycle pulse on e_in 1->0
e_ts  out  N_CH*TS_W  timestamp of last e_rise, channel ch at [ch*TS_W +: TS_W]
e_ts_valid  out  N_CH  1-cycle pulse with each e_ts update

Behaviour:
- Reset is synchronous, active-low, decided: all state updates on posedge clk_96MHz only when rst_n=1.
- Pad tristate:
  - T = !(oe & rst_n), combinational.
  - Pads never driven while rst_n=0.
- Reset values: d_in_0, d_in_1, d_rx_en, e_in, e_rise, e_fall, e_ts_valid = 0; e_ts = 0; timestamp counter = 0; filter counters = 0; guard counters = GUARD_CYCLES (inputs blanked until guard expires).
- Data capture:
  - pos flop samples pad O at posedge; neg flop samples pad O at negedge.
  - Each passes through SYNC_STAGES posedge flops.
  - Pad→d_in_0 latency = SYNC_STAGES+1 posedges; d_in_1 carries the negedge sample preceding that posedge.
  - Data outputs update regardless of d_rx_en.
- Guard, per channel and per pad type:
  - While oe=1, guard counter is loaded with GUARD_CYCLES.
  - When oe=0, it decrements to 0 and saturates.
  - Data: d_rx_en = (d_oe=0 and d_guard=0), registered one cycle.
  - Envelope: blanked while e_oe=1 or e_guard≠0.
- Envelope sync: SYNC_STAGES+1 posedge flops (no negedge path).
- Glitch filter:
  - If synced ≠ e_in, counter increments; otherwise counter clears.
  - When the counter reaches ENV_FILT_LEN-1 and synced still ≠ e_in, e_in toggles and the counter clears.
  - A pulse shorter than ENV_FILT_LEN cycles never propagates.
  - Propagation latency = SYNC_STAGES+1+ENV_FILT_LEN cycles.
- Blanking: filter counter held at 0, e_in holds its value, no e_rise/e_fall/e_ts_valid.
- Edges: e_rise/e_fall asserted in the same cycle e_in changes; never both set.
- Timestamp:
  - Free-running TS_W counter, increments every cycle, wraps 2^TS_W-1→0, no flag.
  - On e_rise, e_ts[ch] ← counter value in that cycle (value before increment), and e_ts_valid[ch]=1 in the same cycle.
  - e_ts holds until the next rise.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset mid-operation: all state returns to reset values next posedge; any in-progress filter count is discarded.

Test Plan:
- Reset, rst_n low 5 cycles, then high, pads idle 0 → d_rx_en=0 for GUARD_CYCLES+1 cycles then 1; e_in=0, no pulses, pads high-Z throughout reset.
- Defaults; envelope ch1 rises and holds 20 cycles, counter value C at the rise cycle → e_in[1]=1 exactly 2+1+4=7 cycles after pad edge; e_rise[1] and e_ts_valid[1] 1 cycle; e_ts[1]=C; channels 0/2 unchanged.
- Envelope ch0 glitch high 3 cycles (ENV_FILT_LEN=4) → e_in[0] stays 0, no e_rise; 4-cycle pulse → e_in[0] goes high then low, e_rise then e_fall.
- Data ch2 driven d_out=1, d_oe=1 for 10 cycles, then released → pad driven 1; d_rx_en[2]=0 during drive and 8 cycles after; e_oe=1 while envelope pad toggled externally → no envelope pulses.
- Data pad toggling at half-clock rate (pad value changes each half-period, 1 posedge/0 negedge) → d_in_0 constant 1, d_in_1 constant 0 after SYNC_STAGES+1 cycles.
- TS_W=4, envelope rises at counter 15 and again after wrap at counter 2 → e_ts=15 then 2.
- All three envelopes rise in the same cycle → three e_ts_valid pulses in one cycle with equal e_ts.
- Reset asserted mid filter count → e_in stays 0 after release.

Source files
------------

// File: rtl/inout_face_manager_n.sv
// Pad manager for N_CH sensor data/envelope pad pairs: tristate control, dual-edge data
// capture, and a guarded, glitch-filtered envelope path with rise-edge timestamps.
module inout_face_manager_n #(
  parameter int N_CH         = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int ENV_FILT_LEN = 4,
  parameter int GUARD_CYCLES = 8,
  parameter int TS_W         = 16
) (
  input  logic                 clk_96MHz,
  input  logic                 rst_n,
  inout  wire  [N_CH-1:0]      data_wire,
  input  logic [N_CH-1:0]      d_oe,
  input  logic [N_CH-1:0]      d_out,
  output logic [N_CH-1:0]      d_in_0,
  output logic [N_CH-1:0]      d_in_1,
  output logic [N_CH-1:0]      d_rx_en,
  inout  wire  [N_CH-1:0]      envelop_wire,
  input  logic [N_CH-1:0]      e_oe,
  input  logic [N_CH-1:0]      e_out,
  output logic [N_CH-1:0]      e_in,
  output logic [N_CH-1:0]      e_rise,
  output logic [N_CH-1:0]      e_fall,
  output logic [N_CH*TS_W-1:0] e_ts,
  output logic [N_CH-1:0]      e_ts_valid
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int FW = $clog2(ENV_FILT_LEN + 1);

  logic [N_CH-1:0] d_t_s;
  logic [N_CH-1:0] e_t_s;
  logic [N_CH-1:0] d_pad_s;
  logic [N_CH-1:0] e_pad_s;
  logic [N_CH-1:0] e_sync_s;
  logic [N_CH-1:0] e_blank_s;

  logic [N_CH-1:0]                    d_pos_q;
  logic [N_CH-1:0]                    d_neg_q;
  logic [SYNC_STAGES-1:0][N_CH-1:0]   d_pos_sync_q;
  logic [SYNC_STAGES:0][N_CH-1:0]     d_neg_sync_q;
  logic [SYNC_STAGES:0][N_CH-1:0]     e_sync_q;

  logic [N_CH-1:0][GW-1:0] d_guard_q, d_guard_d;
  logic [N_CH-1:0][GW-1:0] e_guard_q, e_guard_d;
  logic [N_CH-1:0]         d_rx_en_q, d_rx_en_d;

  logic [N_CH-1:0][FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [N_CH-1:0]         e_in_q, e_in_d;
  logic [N_CH-1:0]         e_rise_q, e_rise_d;
  logic [N_CH-1:0]         e_fall_q, e_fall_d;
  logic [N_CH*TS_W-1:0]    e_ts_q, e_ts_d;
  logic [N_CH-1:0]         e_ts_valid_q, e_ts_valid_d;
  logic [TS_W-1:0]         ts_cnt_q;

  // Pads are released whenever reset is low, regardless of the enables.
  assign d_t_s = ~(d_oe & {N_CH{rst_n}});
  assign e_t_s = ~(e_oe & {N_CH{rst_n}});

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_pad
    assign data_wire[ch]    = d_t_s[ch] ? 1'bz : d_out[ch];
    assign envelop_wire[ch] = e_t_s[ch] ? 1'bz : e_out[ch];
  end

  assign d_pad_s  = data_wire;
  assign e_pad_s  = envelop_wire;
  assign e_sync_s = e_sync_q[SYNC_STAGES];

  // Negedge capture of the data pads.
  always_ff @(negedge clk_96MHz) begin
    if (!rst_n) begin
      d_neg_q <= '0;
    end else begin
      d_neg_q <= d_pad_s;
    end
  end

  // Guard counters reload while driving and count down to zero once released.
  always_comb begin
    d_guard_d = d_guard_q;
    e_guard_d = e_guard_q;
    d_rx_en_d = '0;
    e_blank_s = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (d_oe[ch]) begin
        d_guard_d[ch] = GW'(GUARD_CYCLES);
      end else if (d_guard_q[ch] != GW'(0)) begin
        d_guard_d[ch] = d_guard_q[ch] - GW'(1);
      end else begin
        d_guard_d[ch] = GW'(0);
      end
      if (e_oe[ch]) begin
        e_guard_d[ch] = GW'(GUARD_CYCLES);
      end else if (e_guard_q[ch] != GW'(0)) begin
        e_guard_d[ch] = e_guard_q[ch] - GW'(1);
      end else begin
        e_guard_d[ch] = GW'(0);
      end
      d_rx_en_d[ch] = ~d_oe[ch] & (d_guard_q[ch] == GW'(0));
      e_blank_s[ch] = e_oe[ch] | (e_guard_q[ch] != GW'(0));
    end
  end

  // Envelope glitch filter: the level only flips after ENV_FILT_LEN disagreeing cycles.
  always_comb begin
    filt_cnt_d   = filt_cnt_q;
    e_in_d       = e_in_q;
    e_rise_d     = '0;
    e_fall_d     = '0;
    e_ts_d       = e_ts_q;
    e_ts_valid_d = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (e_blank_s[ch]) begin
        filt_cnt_d[ch] = FW'(0);
      end else if (e_sync_s[ch] != e_in_q[ch]) begin
        if (filt_cnt_q[ch] == FW'(ENV_FILT_LEN - 1)) begin
          filt_cnt_d[ch]             = FW'(0);
          e_in_d[ch]                 = e_sync_s[ch];
          e_rise_d[ch]               = e_sync_s[ch];
          e_fall_d[ch]               = ~e_sync_s[ch];
          e_ts_valid_d[ch]           = e_sync_s[ch];
          e_ts_d[ch*TS_W +: TS_W]    = e_sync_s[ch] ? ts_cnt_q : e_ts_q[ch*TS_W +: TS_W];
        end else begin
          filt_cnt_d[ch] = filt_cnt_q[ch] + FW'(1);
        end
      end else begin
        filt_cnt_d[ch] = FW'(0);
      end
    end
  end

  // All posedge state: synchronisers, guards, filter, edge pulses and timestamp counter.
  always_ff @(posedge clk_96MHz) begin
    if (!rst_n) begin
      d_pos_q      <= '0;
      d_pos_sync_q <= '0;
      d_neg_sync_q <= '0;
      e_sync_q     <= '0;
      d_guard_q    <= {N_CH{GW'(GUARD_CYCLES)}};
      e_guard_q    <= {N_CH{GW'(GUARD_CYCLES)}};
      d_rx_en_q    <= '0;
      filt_cnt_q   <= '0;
      e_in_q       <= '0;
      e_rise_q     <= '0;
      e_fall_q     <= '0;
      e_ts_q       <= '0;
      e_ts_valid_q <= '0;
      ts_cnt_q     <= '0;
    end else begin
      d_pos_q         <= d_pad_s;
      d_pos_sync_q[0] <= d_pos_q;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_pos_sync_q[i] <= d_pos_sync_q[i-1];
      end
      // One extra stage so d_in_1 lines up with the posedge sample that follows it.
      d_neg_sync_q[0] <= d_neg_q;
      e_sync_q[0]     <= e_pad_s;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        d_neg_sync_q[i] <= d_neg_sync_q[i-1];
        e_sync_q[i]     <= e_sync_q[i-1];
      end
      d_guard_q    <= d_guard_d;
      e_guard_q    <= e_guard_d;
      d_rx_en_q    <= d_rx_en_d;
      filt_cnt_q   <= filt_cnt_d;
      e_in_q       <= e_in_d;
      e_rise_q     <= e_rise_d;
      e_fall_q     <= e_fall_d;
      e_ts_q       <= e_ts_d;
      e_ts_valid_q <= e_ts_valid_d;
      ts_cnt_q     <= ts_cnt_q + TS_W'(1);
    end
  end

  assign d_in_0     = d_pos_sync_q[SYNC_STAGES-1];
  assign d_in_1     = d_neg_sync_q[SYNC_STAGES];
  assign d_rx_en    = d_rx_en_q;
  assign e_in       = e_in_q;
  assign e_rise     = e_rise_q;
  assign e_fall     = e_fall_q;
  assign e_ts       = e_ts_q;
  assign e_ts_valid = e_ts_valid_q;

endmodule
